// File: rtl/uart_tx_sched.sv
// uart_tx_sched: byte FIFO between CPU UART stores and txuart, drained under the serializer busy handshake.
module uart_tx_sched #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        ovf,
  output logic [31:0] status
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  logic full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic hcnt_q, hcnt_d, tx_wr_q, tx_wr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic push, pop;
  always_comb begin
    push = wr_valid && !full_q;
    pop = state_q == ISSUE;
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = wr_data;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    full_d = level_d == (AW+1)'(DEPTH);
    empty_d = level_d == '0;
    ovf_d = (wr_valid && full_q) || (ovf_q && !clr_ovf);
    state_d = state_q;
    hcnt_d = hcnt_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (!empty_q && !tx_busy) begin
        state_d = ISSUE;
        tx_data_d = mem_q[rptr_q];
      end
      ISSUE: begin
        state_d = HOLD;
        hcnt_d = 1'b0;
      end
      // two blind cycles cover the serializer's registered busy assertion
      HOLD: begin
        hcnt_d = 1'b1;
        state_d = hcnt_q ? DRAIN : HOLD;
      end
      DRAIN: state_d = tx_busy ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    tx_wr_d = state_d == ISSUE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
      hcnt_q <= 1'b0;
      tx_wr_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      full_q <= full_d;
      empty_q <= empty_d;
      ovf_q <= ovf_d;
      hcnt_q <= hcnt_d;
      tx_wr_q <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb begin
    status = '0;
    status[9] = full_q;
    status[10] = !empty_q || tx_busy || state_q != IDLE;
    status[11] = ovf_q;
    status[16 +: AW+1] = level_q;
  end
  assign tx_wr = tx_wr_q;
  assign tx_data = tx_data_q;
  assign full = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed vectors and sequences for uart_tx_sched with a txuart-like busy model.
module tb_uart_tx_sched;
  localparam int BLEN = 20;
  logic clk = 0, reset = 1, wr_valid = 0, clr_ovf = 0, tx_busy = 0;
  logic [7:0] wr_data = 0;
  logic tx_wr, full, empty, ovf;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic [31:0] status;
  int checks = 0, errors = 0;
  int bdly = 0, brem = 0, since = 0, pulses = 0, max_level = 0;
  bit bauto = 1, seen = 0;
  logic prev_wr = 0;
  logic [7:0] rx[$];
  typedef struct {
    logic wv;
    logic [7:0] wd;
    logic clr;
    logic [4:0] lvl;
    logic fl;
    logic ov;
    logic [31:0] st;
  } vec_t;
  vec_t tbl[20];
  uart_tx_sched #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .status(status)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  // one cycle: monitor at the falling edge, then advance the serializer busy model
  task automatic step();
    @(negedge clk);
    since++;
    if (tx_wr) begin
      chk("tx_wr_single_cycle", 32'(prev_wr), 0);
      if (bauto && seen) chk("tx_wr_gap", 32'(since >= 4 + BLEN), 1);
      seen = 1;
      since = 0;
      pulses++;
      rx.push_back(tx_data);
    end
    prev_wr = tx_wr;
    if (int'(level) > max_level) max_level = int'(level);
    if (bauto) begin
      if (brem > 0) begin
        brem--;
        if (brem == 0) tx_busy = 0;
      end
      if (bdly > 0) begin
        bdly--;
        if (bdly == 0) begin
          tx_busy = 1;
          brem = BLEN;
        end
      end
      if (tx_wr) bdly = 2;
    end
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    wr_valid = 0;
    clr_ovf = 0;
    step();
    step();
    reset = 0;
    seen = 0;
    step();
  endtask
  task automatic push(input logic [7:0] b);
    wr_valid = 1;
    wr_data = b;
    step();
    wr_valid = 0;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 300 && status != 0; n++) step();
    chk("idle_reached", status, 0);
  endtask
  function automatic logic [31:0] stw(int lv, logic f, logic o);
    return {11'd0, 5'(lv), 4'd0, o, 1'b1, f, 9'd0};
  endfunction
  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(8'h60 + i), 1'b0, 5'(i + 1), i == 15, 1'b0, stw(i + 1, i == 15, 1'b0)};
    tbl[16] = '{1'b1, 8'h70, 1'b0, 5'd16, 1'b1, 1'b1, 32'h0010_0E00};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 32'h0010_0600};
    tbl[18] = '{1'b1, 8'h71, 1'b1, 5'd16, 1'b1, 1'b1, 32'h0010_0E00};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 32'h0010_0600};
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_status", status, 0);
    chk("rst_tx_wr", 32'(tx_wr), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_pulses", 32'(pulses), 0);
    push(8'h41);
    chk("single_empty", 32'(empty), 0);
    chk("single_level1", 32'(level), 1);
    chk("single_no_wr_yet", 32'(tx_wr), 0);
    step();
    chk("single_tx_wr", 32'(tx_wr), 1);
    chk("single_tx_data", 32'(tx_data), 32'h41);
    step();
    chk("single_level0", 32'(level), 0);
    for (int n = 0; n < 100 && !tx_busy; n++) step();
    for (int n = 0; n < 100 && tx_busy; n++) step();
    chk("single_busy_fell", 32'(tx_busy), 0);
    chk("single_act_at_fall", 32'(status[10]), 1);
    step();
    chk("single_act_after", 32'(status[10]), 0);
    chk("single_status", status, 0);
    chk("single_pulses", 32'(pulses), 1);
    rx.delete();
    max_level = 0;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    for (int n = 0; n < 1200 && rx.size() < 16; n++) step();
    chk("order_count", 32'(rx.size()), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) chk($sformatf("order_byte%0d", i), 32'(rx[i]), 32'(8'h10 + i));
    chk("order_peak", 32'(max_level >= 15 && max_level <= 16), 1);
    wait_idle();
    do_reset();
    bauto = 0;
    tx_busy = 1;
    for (int i = 0; i < 20; i++) begin
      wr_valid = tbl[i].wv;
      wr_data = tbl[i].wd;
      clr_ovf = tbl[i].clr;
      step();
      wr_valid = 0;
      clr_ovf = 0;
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].fl));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_status", i), status, tbl[i].st);
      chk($sformatf("vec%0d_empty", i), 32'(empty), 0);
    end
    rx.delete();
    bdly = 0;
    brem = 0;
    tx_busy = 0;
    bauto = 1;
    for (int n = 0; n < 1000 && rx.size() < 16; n++) step();
    repeat (60) step();
    chk("drain_count", 32'(rx.size()), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) chk($sformatf("drain_byte%0d", i), 32'(rx[i]), 32'(8'h60 + i));
    wait_idle();
    do_reset();
    bauto = 0;
    tx_busy = 1;
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
    chk("cont_level_pre", 32'(level), 3);
    tx_busy = 0;
    step();
    chk("cont_issue", 32'(tx_wr), 1);
    push(8'h33);
    chk("cont_level_same", 32'(level), 3);
    tx_busy = 1;
    step();
    do_reset();
    tx_busy = 1;
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    chk("mid_level5", 32'(level), 5);
    bdly = 0;
    brem = 0;
    tx_busy = 0;
    bauto = 1;
    step();
    chk("mid_issue", 32'(tx_wr), 1);
    step();
    chk("mid_hold_level", 32'(level), 4);
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    chk("mid_empty", 32'(empty), 1);
    chk("mid_level0", 32'(level), 0);
    chk("mid_tx_wr", 32'(tx_wr), 0);
    begin
      int p0;
      p0 = pulses;
      repeat (60) step();
      chk("mid_no_more_wr", 32'(pulses), 32'(p0));
    end
    chk("mid_status_idle", status, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler between the CPU's memory-mapped IO port and the `txuart` serializer. CPU stores to the UART data word are queued in a byte FIFO, so firmware no longer spins on `uartBusy` per byte. A sequencer drains the FIFO one byte at a time under the serializer's busy handshake. It also produces the 32-bit UART control-register read word.

## Interface

Parameters:

- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.

Ports:

- `clk`  in  1: system clock. One clock domain.
- `reset`  in  1: synchronous, active-high.
- `wr_valid`  in  1: one-cycle push strobe; `IO_memWr & IO_wordAddr[1]`.
- `wr_data`  in  8: byte to queue; `IO_memWData[7:0]`.
- `clr_ovf`  in  1: clears the sticky overflow flag.
- `tx_busy`  in  1: serializer busy; `o_busy` of `txuart`.
- `tx_wr`  out  1: one-cycle write strobe to serializer `i_wr`.
- `tx_data`  out  8: byte to serializer `i_data`; stable from the `tx_wr` cycle until the next pop.
- `full`  out  1: FIFO holds `DEPTH` entries.
- `empty`  out  1: FIFO holds 0 entries.
- `level`  out  AW+1: current occupancy, 0..`DEPTH`.
- `ovf`  out  1: sticky flag; a push was dropped.
- `status`  out  32: control-register read word, layout given under Operation.

## Operation

- FIFO storage:
  - Circular buffer of `DEPTH` bytes.
  - Read and write pointers are AW bits and wrap modulo `DEPTH`.
  - `level` is a separate AW+1-bit counter.
- Push:
  - Accepted when `wr_valid && !full`. Byte is written at `wptr`; `wptr` increments.
  - `wr_valid && full` drops the byte, sets `ovf`, and leaves FIFO contents unchanged.
  - `full` is evaluated before the edge, so a pop in the same cycle does not make room for that push.
- Overflow flag:
  - `ovf` is cleared by `clr_ovf` or `reset`.
  - If a set event and `clr_ovf` occur in the same cycle, set wins.
- Sequencer FSM, states IDLE, ISSUE, HOLD, DRAIN:
  - IDLE: if `!empty && !tx_busy`, go to ISSUE. Otherwise stay.
  - ISSUE:
    - Assert `tx_wr` for exactly this cycle.
    - `tx_data` equals `mem[rptr]`.
    - Pop at the end of the cycle: `rptr` increments, `level` decrements.
    - Go to HOLD.
  - HOLD:
    - Fixed 2 cycles, using a 1-bit counter.
    - `tx_busy` is ignored; this covers the serializer's registered busy assertion.
    - Then go to DRAIN.
  - DRAIN: stay until `tx_busy == 0`, then go to IDLE.
- `tx_data` is a register loaded from `mem[rptr]` on entry to ISSUE. It holds its value otherwise.
- Simultaneous push and pop:
  - `level` is unchanged.
  - Both pointers advance.
  - A push into an empty FIFO cannot pop in the same cycle.
- Status word:
  - Bit 9 = `full`. Firmware polling bit 9 as "busy" remains correct.
  - Bit 10 = `!empty || tx_busy || state != IDLE` (transmit activity).
  - Bit 11 = `ovf`.
  - Bits 16+:AW+1 = `level`.
  - All other bits are 0.
- Reset mid-operation:
  - FIFO is flushed (pointers and `level` = 0).
  - FSM goes to IDLE; `ovf` = 0.
  - A byte already handed to the serializer finishes there. It is not re-queued.

## Timing

- Reset values:
  - `tx_wr` = 0, `tx_data` = 0.
  - `empty` = 1, `full` = 0, `level` = 0, `ovf` = 0.
  - `status` = 0, except that bit 10 follows `tx_busy`.
- Registered outputs: `full`, `empty`, `level`, `ovf`, `tx_wr`, `tx_data`.
- `status` is combinational from those registers, the FSM state and `tx_busy`.
- Latency:
  - Push at edge N into an empty FIFO, with the serializer idle: `empty` = 0 after N, FSM in IDLE.
  - ISSUE at N+1, so `tx_wr` is high in cycle N+1 → N+2.
- Back-to-back bytes:
  - Next ISSUE no earlier than one IDLE cycle after `tx_busy` falls.
  - Minimum gap between `tx_wr` pulses is 4 cycles plus the busy duration.
- `tx_wr` is never high in two consecutive cycles.
- `tx_wr` is never asserted while `tx_busy` is sampled high in IDLE.

## Test plan

- Reset behaviour: hold `reset` 3 cycles, then release. Required: `empty` = 1, `level` = 0, `status` = 0x00000000 with `tx_busy` = 0, and no `tx_wr`.
- Single byte: push 0x41 with the busy model idle (busy high 2 cycles after `tx_wr`, for 20 cycles). Required:
  - exactly one `tx_wr`, in the cycle after the push, with `tx_data` = 0x41;
  - `level` goes 1 → 0;
  - status bit 10 drops after busy falls plus one cycle.
- Ordering: push 0x10..0x1F back-to-back. Required: 16 `tx_wr` pulses in order 0x10..0x1F, each only after the prior busy fell, and `level` peaks at 15 or 16.
- Fill and overflow: hold `tx_busy` = 1, push 17 bytes. Required:
  - `full` = 1 and `level` = 16;
  - `ovf` = 1 after the 17th push, status = 0x0010_0E00;
  - the 17th byte never appears on `tx_data`.
- Clear and contention:
  - `clr_ovf` alone → `ovf` = 0.
  - `clr_ovf` together with a dropped push → `ovf` stays 1.
  - Push while ISSUE pops, with the FIFO at 3 entries → `level` stays 3.
- Reset mid-drain: 5 bytes queued, reset asserted during HOLD. Required: FIFO empty, FSM in IDLE, and no further `tx_wr` after reset deasserts.
